issue_sched: RTL and testbench
==============================

# issue_sched

Issue scheduler for the out-of-order integer back end. It picks, each cycle, at most one of four issue queues (integer, memory, multiply, divide) to dispatch to its execution unit. It also reserves the common data bus (CDB) slot where that unit's result will appear, so that two units never broadcast in the same cycle. The divider is non-pipelined, so the block also tracks its occupancy. `grant` is combinational and drives each execution unit's `issue_granted` input directly.

## Interface
Parameters:
- `INT_LAT`, 1, integer unit result latency in cycles (1..15)
- `MEM_LAT`, 2, load/store unit latency (1..15)
- `MUL_LAT`, 4, multiplier latency, pipelined (1..15)
- `DIV_LAT`, 8, divider latency, non-pipelined (1..15)

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  branch-mispredict flush; cancels all in-flight reservations
- `req`  in  4  issue requests: bit0 int, bit1 mem, bit2 mul, bit3 div
- `grant`  out  4  one-hot-or-zero issue grant, same cycle as `req`
- `cdb_busy`  out  1  a granted result is broadcast on the CDB this cycle
- `div_busy`  out  1  divider occupied; div requests are ineligible
- `rr_ptr`  out  2  current round-robin start index (debug/verification)

## Operation
- `MAX_LAT` = maximum of the four latencies.
- State:
  - reservation vector `rsv[MAX_LAT-1:0]`; `rsv[k]` = CDB taken k cycles from now
  - divider counter `div_cnt` (4 bits)
  - `rr_ptr` (2 bits)
- Eligibility of unit u with latency L_u: `req[u]` & !`rsvx[L_u]` & !(u==div & `div_busy`), where `rsvx[L]` = `rsv[L]` for L<MAX_LAT and 0 otherwise.
- Selection: at most one grant per cycle.
  - The search starts at `rr_ptr`, ascending modulo 4.
  - The first eligible unit is granted.
  - If none is eligible, `grant`=0.
- `grant` is forced to 0 while `flush` or `rst` is asserted.
- Reservation update each edge: `rsv_next[k]` = `rsv[k+1]` (0 for k=MAX_LAT-1) | (grant to unit u with L_u==k+1).
- `cdb_busy` = `rsv[0]`.
- Divider counter:
  - on a div grant, `div_cnt_next` = DIV_LAT-1
  - otherwise it decrements while nonzero
  - `div_busy` = (`div_cnt`!=0)
  - a new div can be granted exactly DIV_LAT cycles after the previous one
- `rr_ptr`: after a grant to u, `rr_ptr_next` = (u+1) mod 4; unchanged if there is no grant.
- Flush:
  - next state `rsv`=0, `div_cnt`=0; `rr_ptr` is unchanged
  - flush overrides a concurrent `req`
- Reset: `rsv`=0, `div_cnt`=0, `rr_ptr`=0. Outputs are therefore `grant`=0, `cdb_busy`=0, `div_busy`=0, `rr_ptr`=0, asserted mid-operation too (in-flight reservations are discarded).

## Timing
- Issue decision latency is 0 cycles: `grant` is a combinational function of `req` and registered state.
- A grant to unit u at cycle t means `cdb_busy`=1 at cycle t+L_u, and no other grant can target that cycle.
- A request held across a blocked cycle needs no handshake beyond the level `req`. The queue keeps `req` asserted until it sees `grant`.
- Divider: a grant at t gives `div_busy`=1 during t+1..t+DIV_LAT-1 and 0 at t+DIV_LAT.
- No latency may exceed 15; MAX_LAT sizes the vector.

## Configuration
- `ISSUE_SCHED_RR_EN` defined: round-robin selection as above; `rr_ptr` advances.
- Not defined: fixed priority div > mul > mem > int among eligible units; `rr_ptr` is held at 0.
- Eligibility, reservation and flush behaviour are identical in both builds.

## Test plan
- Reset then `req`=4'b0001 at cycle t -> `grant`=4'b0001 at t, `cdb_busy`=1 at t+1 only, `rr_ptr`=1 at t+1.
- Slot conflict:
  - `req`=4'b0100 at t -> mul granted, result slot t+4.
  - `req`=4'b0010 from t+2 -> `grant`=0 at t+2 (slot t+4 taken).
  - `grant`=4'b0010 at t+3.
  - `cdb_busy` high at t+4 and t+5.
- Divider occupancy: `req`=4'b1000 held continuously from t -> grants at t and t+8 only; `div_busy`=1 during t+1..t+7.
- Arbitration, with `rr_ptr`=0 and `req`=4'b0101 at t:
  - with the macro: `grant`=4'b0001
  - without: `grant`=4'b0100
- Flush:
  - mul granted at t, `flush`=1 at t+1 -> `cdb_busy` stays 0 at t+4.
  - A div granted at t-2, flushed at t+1 -> `div_busy`=0 at t+2, and a new div request is granted at t+2.
- Reset mid-operation: mul granted at t, `rst` pulsed at t+2 (asynchronously, mid-cycle) -> all outputs 0 immediately; `cdb_busy`=0 at t+4.

Source files
------------

// File: rtl/issue_sched.sv
// issue_sched: picks at most one of four issue queues (int, mem, mul, div)
// per cycle, reserves the CDB slot where that unit's result will land, and
// tracks occupancy of the non-pipelined divider.
//
// Build option: define ISSUE_SCHED_RR_EN for round-robin selection starting
// at rr_ptr; leave it undefined for fixed priority div > mul > mem > int
// (rr_ptr then stays at 0).
//
// rsv[k] = CDB is already claimed k cycles from now. A grant to a unit with
// latency L sets bit L-1 of the next vector, which reaches bit 0 (cdb_busy)
// exactly L cycles after the grant.

module issue_sched #(
  parameter int INT_LAT = 1,
  parameter int MEM_LAT = 2,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       cdb_busy,
  output logic       div_busy,
  output logic [1:0] rr_ptr
);

  localparam int MAX_LO  = (INT_LAT > MEM_LAT) ? INT_LAT : MEM_LAT;
  localparam int MAX_HI  = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MAX_LAT = (MAX_LO > MAX_HI) ? MAX_LO : MAX_HI;

  logic [MAX_LAT-1:0] rsv;
  logic [MAX_LAT-1:0] rsv_next;
  logic [3:0]         div_cnt;
  logic [3:0]         elig;

  // Unit index to result latency; index order matches the req bit order.
  function automatic int lat_of(input int u);
    case (u)
      0:       lat_of = INT_LAT;
      1:       lat_of = MEM_LAT;
      2:       lat_of = MUL_LAT;
      default: lat_of = DIV_LAT;
    endcase
  endfunction

  // A slot beyond the end of the vector can never be taken yet, so the
  // lookup falls back to 0 instead of indexing out of range.
  function automatic logic slot_taken(input logic [MAX_LAT-1:0] v, input int lat);
    slot_taken = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (k == lat) slot_taken = v[k];
    end
  endfunction

  assign cdb_busy = rsv[0];
  assign div_busy = (div_cnt != 4'd0);

  // A unit is eligible when it requests, its result slot is free and,
  // for the divider, the previous divide has drained.
  always_comb begin
    elig = '0;
    for (int u = 0; u < 4; u++) begin
      elig[u] = req[u] & ~slot_taken(rsv, lat_of(u));
    end
    elig[3] = elig[3] & ~div_busy;
  end

`ifdef ISSUE_SCHED_RR_EN
  logic [1:0] grant_idx;

  // Round-robin pick: first eligible unit at or after rr_ptr, wrapping.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    if (flush || rst) grant = '0;
  end

  // grant is one-hot, so its index is a plain OR-encode.
  assign grant_idx = {grant[3] | grant[2], grant[3] | grant[1]};

  // Pointer moves just past the unit that won; held when nothing issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 2'd0;
    end else if (grant != 4'd0) begin
      rr_ptr <= grant_idx + 2'd1;
    end
  end
`else
  // Fixed priority: div > mul > mem > int.
  always_comb begin
    grant = '0;
    if (elig[3])      grant = 4'b1000;
    else if (elig[2]) grant = 4'b0100;
    else if (elig[1]) grant = 4'b0010;
    else if (elig[0]) grant = 4'b0001;
    if (flush || rst) grant = '0;
  end

  // No rotation in this build; the pointer output is tied to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr <= 2'd0;
    else     rr_ptr <= 2'd0;
  end
`endif

  // Next reservation vector: age every slot by one and claim the slot of
  // the unit granted this cycle; a flush drops every outstanding claim.
  always_comb begin
    rsv_next = rsv >> 1;
    for (int u = 0; u < 4; u++) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        if (grant[u] && (k == lat_of(u) - 1)) rsv_next[k] = 1'b1;
      end
    end
    if (flush) rsv_next = '0;
  end

  // Reservation register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsv <= '0;
    else     rsv <= rsv_next;
  end

  // Divider occupancy: loaded with DIV_LAT-1 on a div grant so the next
  // divide can issue exactly DIV_LAT cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= 4'd0;
    end else if (flush) begin
      div_cnt <= 4'd0;
    end else if (grant[3]) begin
      div_cnt <= 4'(DIV_LAT - 1);
    end else if (div_cnt != 4'd0) begin
      div_cnt <= div_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_issue_sched.sv
// Bench for issue_sched: a cycle-indexed booking model (calendar of claimed
// CDB cycles plus a divider free-at time) produces the expected outputs for
// each driven cycle; they are queued when the stimulus is applied and
// compared when the DUT outputs settle on the falling edge.
module tb_issue_sched;

  localparam int INT_LAT = 1;
  localparam int MEM_LAT = 2;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] req;
  logic [3:0] grant;
  logic       cdb_busy;
  logic       div_busy;
  logic [1:0] rr_ptr;

  issue_sched #(
    .INT_LAT(INT_LAT), .MEM_LAT(MEM_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .req(req),
    .grant(grant), .cdb_busy(cdb_busy), .div_busy(div_busy), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic       cdb;
    logic       db;
    logic [1:0] rr;
  } exp_t;

  exp_t sb_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  bit   booked[0:4095];
  int   div_free_at = 0;
  logic [1:0] m_rr = 2'd0;
  int   cyc = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  function automatic int lat_of(input int u);
    case (u)
      0:       return INT_LAT;
      1:       return MEM_LAT;
      2:       return MUL_LAT;
      default: return DIV_LAT;
    endcase
  endfunction

  task automatic model_reset();
    foreach (booked[i]) booked[i] = 1'b0;
    div_free_at = 0;
    m_rr = 2'd0;
  endtask

  // One clock cycle: drive, optionally pulse reset mid-cycle, predict, compare.
  task automatic step(input logic [3:0] r, input logic f, input bit pulse_rst);
    exp_t e, o;
    logic [3:0] el;
    int n;
    @(posedge clk);
    #1;
    req   = r;
    flush = f;
    if (pulse_rst) begin
      rst = 1'b1;
      #1;
      chk("rst_grant", grant, 4'd0);
      chk("rst_cdb", {3'd0, cdb_busy}, 4'd0);
      chk("rst_div", {3'd0, div_busy}, 4'd0);
      chk("rst_rr", {2'd0, rr_ptr}, 4'd0);
      rst = 1'b0;
      model_reset();
    end
    n     = cyc;
    e.cdb = booked[n];
    e.db  = (n < div_free_at);
    e.rr  = m_rr;
    e.g   = 4'd0;
    el    = 4'd0;
    for (int u = 0; u < 4; u++)
      el[u] = r[u] && !booked[n + lat_of(u)] && !(u == 3 && e.db);
    if (!f) begin
`ifdef ISSUE_SCHED_RR_EN
      for (int i = 0; i < 4; i++) begin
        int idx;
        idx = (int'(m_rr) + i) % 4;
        if (e.g == 4'd0 && el[idx]) e.g[idx] = 1'b1;
      end
`else
      if (el[3])      e.g = 4'b1000;
      else if (el[2]) e.g = 4'b0100;
      else if (el[1]) e.g = 4'b0010;
      else if (el[0]) e.g = 4'b0001;
`endif
    end
    for (int u = 0; u < 4; u++) begin
      if (e.g[u]) begin
        booked[n + lat_of(u)] = 1'b1;
        if (u == 3) div_free_at = n + DIV_LAT;
`ifdef ISSUE_SCHED_RR_EN
        m_rr = 2'((u + 1) % 4);
`endif
      end
    end
    if (f) begin
      for (int k = n + 1; k <= n + 16; k++) booked[k] = 1'b0;
      if (div_free_at > n + 1) div_free_at = n + 1;
    end
    sb_q.push_back(e);
    @(negedge clk);
    o = sb_q.pop_front();
    chk("grant", grant, o.g);
    chk("cdb_busy", {3'd0, cdb_busy}, {3'd0, o.cdb});
    chk("div_busy", {3'd0, div_busy}, {3'd0, o.db});
    chk("rr_ptr", {2'd0, rr_ptr}, {2'd0, o.rr});
    cyc++;
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) step(4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    req   = 4'd0;
    flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_grant", grant, 4'd0);
    chk("init_cdb", {3'd0, cdb_busy}, 4'd0);
    chk("init_div", {3'd0, div_busy}, 4'd0);
    chk("init_rr", {2'd0, rr_ptr}, 4'd0);
    rst = 1'b0;

    // single int issue: grant now, CDB busy next cycle only
    step(4'b0001, 1'b0, 1'b0);
    idle(3);

    // slot conflict: mul at t claims t+4; mem blocked at t+2, granted at t+3
    step(4'b0100, 1'b0, 1'b0);
    idle(1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    idle(4);

    // divider held request: grants at t and t+8 only
    for (int i = 0; i < 10; i++) step(4'b1000, 1'b0, 1'b0);
    idle(8);

    // arbitration: last winner was div, so rr_ptr is back at 0
    step(4'b0101, 1'b0, 1'b0);
    idle(5);

    // flush cancels an in-flight mul result
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    idle(4);

    // flush frees the divider; a new divide issues the next cycle
    step(4'b1000, 1'b0, 1'b0);
    idle(2);
    step(4'b1000, 1'b1, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    idle(9);

    // asynchronous reset mid-operation
    step(4'b0100, 1'b0, 1'b0);
    idle(1);
    step(4'b0000, 1'b0, 1'b1);
    idle(4);

    // random traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0), 1'b0);
    idle(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
